// File: rtl/mul_disp_pkg.sv
// Shared constants for the multiplier-check seven-segment display.
// Glyphs are abcdefg with segment a in the MSB, active-low.
package mul_disp_pkg;

  localparam int REFRESH_DIV_DEFAULT = 50000;

  typedef logic [1:0] digit_t;
  typedef logic [6:0] glyph_t;

  localparam digit_t DIGIT_PROD = 2'd0;
  localparam digit_t DIGIT_EQ   = 2'd1;
  localparam digit_t DIGIT_B    = 2'd2;
  localparam digit_t DIGIT_A    = 2'd3;

  localparam glyph_t GLYPH_0      = 7'b0000001;
  localparam glyph_t GLYPH_1      = 7'b1001111;
  localparam glyph_t GLYPH_2      = 7'b0010010;
  localparam glyph_t GLYPH_3      = 7'b0000110;
  localparam glyph_t GLYPH_4      = 7'b1001100;
  localparam glyph_t GLYPH_5      = 7'b0100100;
  localparam glyph_t GLYPH_6      = 7'b0100000;
  localparam glyph_t GLYPH_7      = 7'b0001111;
  localparam glyph_t GLYPH_8      = 7'b0000000;
  localparam glyph_t GLYPH_9      = 7'b0000100;
  localparam glyph_t GLYPH_A      = 7'b0001000;
  localparam glyph_t GLYPH_B      = 7'b1100000;
  localparam glyph_t GLYPH_C      = 7'b0110001;
  localparam glyph_t GLYPH_D      = 7'b1000010;
  localparam glyph_t GLYPH_E      = 7'b0110000;
  localparam glyph_t GLYPH_F      = 7'b0111000;
  localparam glyph_t GLYPH_BLANK  = 7'b1111111;
  localparam glyph_t GLYPH_EQUALS = 7'b1110110;

endpackage

// File: rtl/mul_seg_display_hex_to_seg7.sv
// Hex nibble to active-low seven-segment glyph, purely combinational.
module hex_to_seg7
  import mul_disp_pkg::*;
(
  input  logic [0:3] code_i,
  output logic [0:6] glyph_o
);

  always_comb begin
    case (code_i)
      4'h0:    glyph_o = GLYPH_0;
      4'h1:    glyph_o = GLYPH_1;
      4'h2:    glyph_o = GLYPH_2;
      4'h3:    glyph_o = GLYPH_3;
      4'h4:    glyph_o = GLYPH_4;
      4'h5:    glyph_o = GLYPH_5;
      4'h6:    glyph_o = GLYPH_6;
      4'h7:    glyph_o = GLYPH_7;
      4'h8:    glyph_o = GLYPH_8;
      4'h9:    glyph_o = GLYPH_9;
      4'hA:    glyph_o = GLYPH_A;
      4'hB:    glyph_o = GLYPH_B;
      4'hC:    glyph_o = GLYPH_C;
      4'hD:    glyph_o = GLYPH_D;
      4'hE:    glyph_o = GLYPH_E;
      default: glyph_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/mul_seg_display.sv
// Captures a, b and a 2x2 multiplier result, flags a wrong product, and scans
// "a b = prod" across four multiplexed digits; all outputs registered.
module mul_seg_display
  import mul_disp_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:1] a,
  input  logic [0:1] b,
  input  logic [0:3] prod,
  input  logic       load,
  input  logic       hold,
  output logic [0:6] seg,
  output logic [0:3] an,
  output logic       dp,
  output logic       err
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_t        idx_q, idx_d;
  logic [1:0]    a_q, a_d, b_q, b_d;
  logic [3:0]    prod_q, prod_d;
  logic          valid_q, valid_d, err_q, err_d;
  glyph_t        seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic          tick, capture;
  logic [3:0]    mult, code;
  glyph_t        hex_glyph;

  assign mult = {2'b00, a} * {2'b00, b};

  always_comb begin
    tick    = (cnt_q == CNT_LAST);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;

    // hold has priority over load
    capture = load & ~hold;
    a_d     = capture ? a : a_q;
    b_d     = capture ? b : b_q;
    prod_d  = capture ? prod : prod_q;
    valid_d = capture | valid_q;
    err_d   = capture ? (prod != mult) : err_q;

    case (idx_q)
      DIGIT_A: code = {2'b00, a_q};
      DIGIT_B: code = {2'b00, b_q};
      default: code = prod_q;
    endcase

    if (!valid_q)              seg_d = GLYPH_BLANK;
    else if (idx_q == DIGIT_EQ) seg_d = GLYPH_EQUALS;
    else                       seg_d = hex_glyph;

    an_d = ~(4'b0001 << idx_q);
    dp_d = ~((idx_q == DIGIT_PROD) & err_q);
  end

  hex_to_seg7 u_hex (
    .code_i  (code),
    .glyph_o (hex_glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= DIGIT_PROD;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      seg_q   <= GLYPH_BLANK;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;
  assign err = err_q;

endmodule

// File: tb/tb_mul_seg_display.sv
// Bench for mul_seg_display with a fast refresh; reference model works from edge
// counts since reset and the captured operands.
module tb_mul_seg_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] a, b;
  logic [3:0] prod;
  logic       load, hold;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp, err;

  int total = 0;
  int bad   = 0;

  int         m_n;
  logic       m_valid, m_err;
  logic [1:0] m_a, m_b;
  logic [3:0] m_prod;

  mul_seg_display #(.REFRESH_DIV(DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .prod (prod),
    .load (load),
    .hold (hold),
    .seg  (seg),
    .an   (an),
    .dp   (dp),
    .err  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] prod;
    logic       hold;
    logic       exp_err;
    logic [6:0] exp_dig0;
  } vec_t;

  function automatic logic [6:0] glyph(int v);
    case (v)
      0: return 7'b0000001;  1: return 7'b1001111;
      2: return 7'b0010010;  3: return 7'b0000110;
      4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;
      8: return 7'b0000000;  9: return 7'b0000100;
      10: return 7'b0001000; 11: return 7'b1100000;
      12: return 7'b0110001; 13: return 7'b1000010;
      14: return 7'b0110000; default: return 7'b0111000;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_n = 0; m_valid = 0; m_err = 0; m_a = 0; m_b = 0; m_prod = 0;
  endtask

  // One clock edge: predict from the pre-edge model, then apply the inputs.
  task automatic cyc();
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;
    int         d;
    @(posedge clk);
    if (rst) begin
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
    end else begin
      m_n++;
      d = ((m_n - 1) / DIV) % 4;
      e_an = 4'hF ^ (4'b0001 << d);
      if (!m_valid)   e_seg = 7'h7F;
      else if (d == 3) e_seg = glyph(int'(m_a));
      else if (d == 2) e_seg = glyph(int'(m_b));
      else if (d == 1) e_seg = 7'b1110110;
      else             e_seg = glyph(int'(m_prod));
      e_dp = !(d == 0 && m_err);
      if (load && !hold) begin
        m_a = a; m_b = b; m_prod = prod; m_valid = 1'b1;
        m_err = (int'(prod) != (int'(a) * int'(b)) % 16);
      end
    end
    #1;
    chk("seg", seg, e_seg);
    chk("an",  an,  e_an);
    chk("dp",  dp,  e_dp);
    chk("err", err, m_err);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_seg"}, seg, 7'h7F);
    chk({tag, "_an"},  an,  4'hF);
    chk({tag, "_dp"},  dp,  1'b1);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    vec_t vecs[4];
    logic [6:0] got0;
    int dp_wrong;
    bit found;

    vecs[0] = '{a: 2'd3, b: 2'd3, prod: 4'd9, hold: 1'b0, exp_err: 1'b0, exp_dig0: 7'b0000100};
    vecs[1] = '{a: 2'd2, b: 2'd3, prod: 4'd5, hold: 1'b0, exp_err: 1'b1, exp_dig0: 7'b0100100};
    vecs[2] = '{a: 2'd1, b: 2'd2, prod: 4'd2, hold: 1'b1, exp_err: 1'b1, exp_dig0: 7'b0100100};
    vecs[3] = '{a: 2'd1, b: 2'd2, prod: 4'd2, hold: 1'b0, exp_err: 1'b0, exp_dig0: 7'b0010010};

    rst = 1'b1; a = 0; b = 0; prod = 0; load = 0; hold = 0;
    model_clear();
    #3 chk_reset_vals("por");
    cyc(); cyc();
    #2 rst = 1'b0;

    // Blank scan with no capture yet
    repeat (40) cyc();

    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b; prod = vecs[i].prod;
      hold = vecs[i].hold; load = 1'b1;
      cyc();
      load = 1'b0; hold = 1'b0;
      got0 = 7'h7F; dp_wrong = 0;
      repeat (4 * DIV + 1) begin
        cyc();
        if (an == 4'b1110) got0 = seg;
        if (dp == 1'b0 && an != 4'b1110) dp_wrong++;
      end
      chk("vec_err",  err, vecs[i].exp_err);
      chk("vec_dig0", got0, vecs[i].exp_dig0);
      chk("vec_dp_slot", dp_wrong, 0);
    end

    for (int bi = 3; bi >= 0; bi--) begin
      for (int ai = 3; ai >= 0; ai--) begin
        a = 2'(ai); b = 2'(bi); prod = 4'(ai * bi); load = 1'b1;
        cyc();
        load = 1'b0;
        chk("sweep_err", err, 1'b0);
        repeat (3) cyc();
      end
    end

    for (int k = 0; k < 40; k++) begin
      a = 2'($urandom_range(3)); b = 2'($urandom_range(3));
      prod = ($urandom_range(1) == 0) ? 4'(int'(a) * int'(b)) : 4'($urandom_range(15));
      load = ($urandom_range(2) != 0);
      hold = ($urandom_range(3) == 0);
      repeat ($urandom_range(1, 6)) cyc();
    end
    load = 0; hold = 0;

    found = 0;
    for (int k = 0; k < 5 * DIV && !found; k++) begin
      cyc();
      if (an == 4'b1011) found = 1;
    end
    chk("find_digit2", found, 1'b1);
    #2 rst = 1'b1;
    model_clear();
    #1 chk_reset_vals("arst");
    cyc();
    #2 rst = 1'b0;
    cyc();
    chk("restart_an", an, 4'b1110);
    repeat (20) cyc();
    chk("restart_blank", seg, 7'h7F);

    a = 2'd2; b = 2'd2; prod = 4'd4; load = 1'b1;
    cyc();
    load = 1'b0;
    repeat (4 * DIV + 1) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_seg_display.md
MUL_SEG_DISPLAY -- requirements
Module: mul_seg_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 50000, clock cycles per digit slot (1 kHz per digit at 50 MHz); legal range >= 2.
REQ-002 Vector bit 0 SHALL be the MSB on all ports, matching the two_bit_mul out port.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 a  in  2  multiplicand presented to two_bit_mul.
REQ-006 b  in  2  multiplier presented to two_bit_mul.
REQ-007 prod  in  4  two_bit_mul out, consumed by this block.
REQ-008 load  in  1  capture request for a, b and prod, sampled each clk edge.
REQ-009 hold  in  1  freeze displayed values; load is ignored while high.
REQ-010 seg  out  7  segments a..g, active-low, registered.
REQ-011 an  out  4  digit enables, active-low, one-hot, registered; an bit k selects digit k.
REQ-012 dp  out  1  decimal point, active-low, registered.
REQ-013 err  out  1  captured prod differs from captured a*b, registered.

Function
REQ-014 On a clk edge with load=1 and hold=0, the block SHALL register a, b and prod into capture registers, set valid=1, and set err=(prod != a*b), computed at 4-bit width.
REQ-015 When load=1 and hold=1 on the same edge, hold SHALL win: no capture, and valid and err stay unchanged.
REQ-016 With load=0, the capture registers, valid and err SHALL hold their values.
REQ-017 The refresh counter SHALL count 0..REFRESH_DIV-1, then wrap to 0, and SHALL assert a one-cycle tick on the wrap.
REQ-018 The 2-bit digit index SHALL increment on each tick and wrap 3->0.
REQ-019 Digit map: 3 = captured a (glyph 0-3); 2 = captured b; 1 = "=" glyph (segments d and g lit); 0 = captured prod (hex glyph 0-F).
REQ-020 an and seg SHALL change exactly one cycle after the digit index changes; no two an bits are ever low together.
REQ-021 dp SHALL be low only while digit 0 is selected and err=1; otherwise high.
REQ-022 While valid=0, seg SHALL be all-high (blank), and the an scan SHALL continue normally.
REQ-023 A captured value SHALL appear on its digit within 4*REFRESH_DIV+1 cycles of the capture edge.
REQ-024 hold SHALL NOT stop the refresh scan.

Reset
REQ-025 Asserting rst SHALL immediately set: counter=0, index=0, capture registers=0, valid=0, err=0, seg=7'b1111111, an=4'b1111, dp=1.
REQ-026 After rst deassertion, an SHALL be 4'b1110 (digit 0) on the first clk edge, and scanning SHALL resume from digit 0.
REQ-027 rst asserted mid-scan or mid-capture SHALL discard all state, with no partial capture retained.

Structure
REQ-028 Package mul_disp_pkg SHALL hold: the glyph constants (hex 0-F, BLANK, EQUALS), the REFRESH_DIV default, and the digit index constants.
REQ-029 Sub-module hex_to_seg7 (4-bit code to 7-bit active-low glyph) SHALL be instantiated once, on the selected digit's value.
REQ-030 Target size: 120-400 lines of RTL, excluding the package.

Verification (benches use REFRESH_DIV=4)
REQ-031 Reset only, 40 cycles -> seg=7'b1111111 throughout; an cycles 1110, 1101, 1011, 0111, each held 4 cycles.
REQ-032 a=3, b=3, prod=9, load pulse -> digit 3 shows "3", digit 2 "3", digit 1 "=", digit 0 "9"; err=0; dp=1.
REQ-033 a=2, b=3, prod=5 (fault), load -> err=1, and dp goes low only in the digit 0 slot.
REQ-034 hold=1 with load=1 and a=1, b=2, prod=2 -> displayed values and err unchanged; after hold=0 and a load, they update to 1, 2, =, 2.
REQ-035 Full sweep in order b=3..0, a=3..0 (16 loads) against a golden two_bit_mul -> err=0 on every capture.
REQ-036 rst pulsed while digit 2 is selected -> outputs go to their reset values asynchronously; after release, the scan restarts at digit 0 and the display stays blank until the next load.
